fp_add_sequencer: RTL and testbench

Initiator-side controller for the multi-cycle `Floating_PointAddition` unit. It accepts IEEE-754 single-precision operand pairs over a valid/ready stream and starts the adder by pulsing the adder's active-high `rst`. It waits for `done`, captures `out`, and presents the sum on a valid/ready result stream. A timeout guards against an adder that never completes, so a hung adder cannot stall the datapath.

---
 rtl/fp_add_sequencer.sv | 123 ++++++++++++
 tb/tb_fp_add_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: initiator-side controller for a multi-cycle floating-point
// adder. It loads one operand pair, pulses the adder reset, then waits for
// done (or a timeout) and presents the captured sum on a valid/ready stream.
// Only one operation is in flight at a time.
module fp_add_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int START_PULSE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        fpa_rst,
  output logic [31:0] fpa_a,
  output logic [31:0] fpa_b,
  input  logic        fpa_done,
  input  logic [31:0] fpa_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_timeout,
  output logic        busy
);

  // Counter widths: the pulse counter counts down from START_PULSE-1, the
  // wait counter counts up to TIMEOUT_CYCLES-1.
  localparam int PW = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [PW-1:0] PULSE_LOAD = PW'(START_PULSE - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   QNAN       = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   pulse_cnt_reg;
  logic [TW-1:0]   wait_cnt_reg;
  logic            fpa_rst_reg;
  logic [31:0]     fpa_a_reg;
  logic [31:0]     fpa_b_reg;
  logic [31:0]     result_reg;
  logic            timeout_reg;

  // Sequencer FSM with registered adder controls and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      pulse_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      fpa_rst_reg   <= 1'b1;
      fpa_a_reg     <= '0;
      fpa_b_reg     <= '0;
      result_reg    <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          fpa_rst_reg <= 1'b1;
          if (in_valid) begin
            fpa_a_reg     <= in_a;
            fpa_b_reg     <= in_b;
            pulse_cnt_reg <= PULSE_LOAD;
            state_reg     <= S_START;
          end
        end
        S_START: begin
          // done is deliberately ignored here: it may be stale from the
          // previous operation until the adder sees its reset.
          if (pulse_cnt_reg == '0) begin
            wait_cnt_reg <= '0;
            fpa_rst_reg  <= 1'b0;
            state_reg    <= S_WAIT;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
          end
        end
        S_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          // done is checked first so it wins over a coincident timeout
          if (fpa_done) begin
            result_reg  <= fpa_out;
            timeout_reg <= 1'b0;
            fpa_rst_reg <= 1'b1;
            state_reg   <= S_HOLD;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            result_reg  <= QNAN;
            timeout_reg <= 1'b1;
            fpa_rst_reg <= 1'b1;
            state_reg   <= S_HOLD;
          end
        end
        S_HOLD: begin
          fpa_rst_reg <= 1'b1;
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          fpa_rst_reg <= 1'b1;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_reg == S_IDLE);
  assign out_valid   = (state_reg == S_HOLD);
  assign busy        = (state_reg != S_IDLE);
  assign fpa_rst     = fpa_rst_reg;
  assign fpa_a       = fpa_a_reg;
  assign fpa_b       = fpa_b_reg;
  assign out_result  = result_reg;
  assign out_timeout = timeout_reg;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed vectors for fp_add_sequencer with a small
// behavioural adder model whose done timing is set per transaction.
module tb_fp_add_sequencer;

  localparam int TIMEOUT_CYCLES = 64;
  localparam int START_PULSE    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        fpa_rst;
  logic [31:0] fpa_a;
  logic [31:0] fpa_b;
  logic        fpa_done;
  logic [31:0] fpa_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_timeout;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Adder model controls: done_at = WAIT cycle on which done is raised
  // (0 = never); stale_en drives done high while the adder is in reset.
  int          done_at  = 0;
  logic        stale_en = 1'b0;
  logic [31:0] model_sum = '0;
  int          wcnt = 0;

  fp_add_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .START_PULSE   (START_PULSE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .fpa_rst    (fpa_rst),
    .fpa_a      (fpa_a),
    .fpa_b      (fpa_b),
    .fpa_done   (fpa_done),
    .fpa_out    (fpa_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_timeout(out_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Adder model: counts cycles out of reset, WAIT cycle 1 has wcnt==1
  always @(posedge clk) begin
    if (fpa_rst) wcnt <= 1;
    else         wcnt <= wcnt + 1;
  end

  assign fpa_done = fpa_rst ? stale_en : ((done_at != 0) && (wcnt == done_at));
  assign fpa_out  = model_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction. Called at a negedge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sum, input int dn, input logic stale,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_to, input int hold_cycles);
    int   k;
    int   pulse;
    logic pulse_done;
    logic ready_seen;
    model_sum = sum;
    done_at   = dn;
    stale_en  = stale;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold_cycles == 0);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    in_a       = 32'hDEAD_BEEF;
    in_b       = 32'hDEAD_BEEF;
    k          = 0;
    pulse      = 0;
    pulse_done = 1'b0;
    ready_seen = 1'b0;
    while (!out_valid && k < 200) begin
      if (fpa_rst && !pulse_done) pulse++;
      else                        pulse_done = 1'b1;
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_pulse_len"}, 32'(pulse), 32'(START_PULSE));
    check({tag, "_in_ready_busy"}, 32'(ready_seen), 32'd0);
    check({tag, "_fpa_a"}, fpa_a, a);
    check({tag, "_fpa_b"}, fpa_b, b);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_timeout"}, 32'(out_timeout), 32'(exp_to));
    // Backpressure: result must hold still, and new input must be refused
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = 1'b1;
      in_a     = 32'h1111_1111;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_result"}, out_result, exp_res);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_fpa_a"}, fpa_a, a);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
    $display("[TB] %s a=%h b=%h result=%h timeout=%0d latency=%0d", tag, a, b,
             out_result, out_timeout, k);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_fpa_rst",   32'(fpa_rst), 32'd1);
    check("rst_fpa_a",     fpa_a, 32'h0);
    check("rst_fpa_b",     fpa_b, 32'h0);
    check("rst_result",    out_result, 32'h0);
    check("rst_timeout",   32'(out_timeout), 32'd0);
    $display("[TB] reset checked");
    rst = 1'b1;
    @(negedge clk);

    // 12.125 + 30.4375 = 42.5625, done on WAIT cycle 4, out_ready held high
    run_op("basic", 32'h4142_0000, 32'h41F3_8000, 32'h422A_4000, 4, 1'b0,
           START_PULSE + 4, 32'h422A_4000, 1'b0, 0);

    // -20.75 + -15.25 = -36, backpressure for 5 HOLD cycles
    run_op("backpressure", 32'hC1A6_0000, 32'hC174_0000, 32'hC210_0000, 2, 1'b0,
           START_PULSE + 2, 32'hC210_0000, 1'b0, 5);

    // Adder never completes: forced qNaN
    run_op("timeout", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, 1'b0,
           START_PULSE + TIMEOUT_CYCLES, 32'h7FC0_0000, 1'b1, 0);

    // Stale done high during START must be ignored; real done on WAIT cycle 3
    run_op("stale_done", 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, 3, 1'b1,
           START_PULSE + 3, 32'h40A0_0000, 1'b0, 0);
    stale_en = 1'b0;

    // Reset asserted during WAIT cycle 2 discards the operation
    model_sum = 32'h40A8_0000;
    done_at   = 3;
    in_a      = 32'h40A8_0000;
    in_b      = 32'h0000_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (START_PULSE + 1) @(negedge clk);
    check("midrst_in_wait", 32'(fpa_rst), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready), 32'd1);
    check("midrst_fpa_rst",   32'(fpa_rst), 32'd1);
    check("midrst_busy",      32'(busy), 32'd0);
    @(negedge clk);
    check("midrst_no_result", 32'(out_valid), 32'd0);
    $display("[TB] mid-operation reset checked");
    out_ready = 1'b0;
    run_op("after_rst", 32'h40A8_0000, 32'h0000_0000, 32'h40A8_0000, 2, 1'b0,
           START_PULSE + 2, 32'h40A8_0000, 1'b0, 0);

    // done arrives on the same edge the timeout count is reached: done wins
    run_op("done_vs_timeout", 32'h4120_0000, 32'h4120_0000, 32'h41A0_0000,
           TIMEOUT_CYCLES, 1'b0, START_PULSE + TIMEOUT_CYCLES, 32'h41A0_0000, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
